mux64_rr_arbiter: RTL and testbench

Round-robin, packet-aware arbiter sharing the 64-bit 4:1 output mux (`mux64_4_2`) between four streaming requesters. It picks one requester, steers that requester's beats through the mux into a single registered output stage, and holds the grant until that requester's packet ends. It sits directly in front of the shared 64-bit downstream path and generates the mux select that is otherwise driven externally.

---
 rtl/mux64_rr_arbiter.sv | 133 +++++++++++++
 tb/tb_mux64_rr_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux64_rr_arbiter.sv
// Packet-aware round-robin arbiter sharing a 64-bit 4:1 mux between four
// streaming requesters, with a single registered output stage.
module mux64_rr_arbiter #(
  parameter int unsigned DATA_W = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            in_valid,
  input  logic [4*DATA_W-1:0]   in_data,
  input  logic [3:0]            in_last,
  output logic [3:0]            in_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_last,
  output logic [1:0]            out_src,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned IDX_W   = 2;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   lock_idx_q, lock_idx_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [IDX_W-1:0]   sel;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   cand;
  logic               win_found;
  logic               stage_free;
  logic               load;
  logic [NUM_REQ-1:0] ready_c;
  logic [DATA_W-1:0]  mux_out;

  assign stage_free = !out_valid || out_ready;
  assign busy       = (state_q == LOCKED);
  // in_ready is forced low while reset is asserted so no handshake is seen
  assign in_ready   = ready_c & {NUM_REQ{rst_n}};

  // Rotating-priority search starting just after the last granted requester
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = last_grant_q + IDX_W'(i);
      if (!win_found && in_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Shared 64-bit 4:1 data mux
  always_comb begin
    mux_out = '0;
    case (sel)
      2'd0:    mux_out = in_data[0*DATA_W +: DATA_W];
      2'd1:    mux_out = in_data[1*DATA_W +: DATA_W];
      2'd2:    mux_out = in_data[2*DATA_W +: DATA_W];
      default: mux_out = in_data[3*DATA_W +: DATA_W];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      lock_idx_q   <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_q      <= state_d;
      lock_idx_q   <= lock_idx_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    lock_idx_d   = lock_idx_q;
    last_grant_d = last_grant_q;
    sel          = '0;
    ready_c      = '0;
    load         = 1'b0;
    case (state_q)
      IDLE: begin
        sel = win_idx;
        if (win_found && stage_free) begin
          ready_c[win_idx] = 1'b1;
          load             = 1'b1;
          if (in_last[win_idx]) begin
            last_grant_d = win_idx;
          end else begin
            state_d    = LOCKED;
            lock_idx_d = win_idx;
          end
        end
      end
      LOCKED: begin
        // Gaps in the locked requester's valid hold the lock
        sel = lock_idx_q;
        if (stage_free && in_valid[lock_idx_q]) begin
          ready_c[lock_idx_q] = 1'b1;
          load                = 1'b1;
          if (in_last[lock_idx_q]) begin
            state_d      = IDLE;
            last_grant_d = lock_idx_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output stage: load replaces contents; drain alone only clears valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= mux_out;
      out_last  <= in_last[sel];
      out_src   <= sel;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux64_rr_arbiter.sv
// Self-checking bench for mux64_rr_arbiter: vector table, corner sequences,
// and random stress, all checked against a reference model and scoreboard.
module tb_mux64_rr_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   in_valid;
  logic [255:0] in_data;
  logic [3:0]   in_last;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic [63:0]  out_data;
  logic         out_last;
  logic [1:0]   out_src;
  logic         out_ready;
  logic         busy;

  mux64_rr_arbiter #(.DATA_W(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_src   (out_src),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic [1:0]  src;
  } beat_t;

  typedef struct {
    logic [3:0] v;
    logic [3:0] l;
    logic       ordy;
    logic [3:0] exp_rdy;
    logic       exp_busy;
  } vec_t;

  beat_t       sb[$];
  vec_t        tbl[17];
  logic [63:0] req_data[4];
  int          n_cmp = 0;
  int          n_err = 0;

  // reference model state
  logic        m_ov;
  logic        m_locked;
  logic [1:0]  m_lock;
  logic [1:0]  m_lg;
  logic        open_v;
  logic [1:0]  open_src;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_ov = 1'b0; m_locked = 1'b0; m_lock = 2'd0; m_lg = 2'd3; open_v = 1'b0; open_src = 2'd0;
  endtask

  // One cycle: drive at negedge, check pre-edge, advance model for the coming edge
  task automatic step(input logic [3:0] v, input logic [3:0] l, input logic ordy);
    logic [3:0] er;
    logic       sf;
    logic       found;
    logic [1:0] a;
    logic [1:0] c;
    beat_t      b;
    @(negedge clk);
    in_valid  = v;
    in_last   = l;
    out_ready = ordy;
    for (int k = 0; k < 4; k++) in_data[64*k +: 64] = req_data[k];
    #1;
    sf = !m_ov || ordy;
    er = 4'b0; found = 1'b0; a = 2'd0;
    if (m_locked) begin
      a = m_lock; found = v[m_lock];
    end else begin
      for (int i = 1; i <= 4; i++) begin
        c = m_lg + 2'(i);
        if (!found && v[c]) begin found = 1'b1; a = c; end
      end
    end
    if (found && sf) er[a] = 1'b1;
    chk("in_ready", 64'(in_ready), 64'(er));
    chk("ready_onehot", 64'($countones(in_ready) <= 1), 64'(1));
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    chk("busy", 64'(busy), 64'(m_locked));
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 64'(sb.size()), 64'(1));
      end else begin
        b = sb.pop_front();
        chk("out_data", out_data, b.data);
        chk("out_last", 64'(out_last), 64'(b.last));
        chk("out_src", 64'(out_src), 64'(b.src));
        if (open_v) chk("no_interleave", 64'(out_src), 64'(open_src));
        open_v   = !b.last;
        open_src = b.src;
      end
    end
    if (er != 4'b0) begin
      b.data = req_data[a]; b.last = l[a]; b.src = a;
      sb.push_back(b);
      req_data[a] = req_data[a] + 64'd1;
      m_ov = 1'b1;
      if (l[a]) begin m_locked = 1'b0; m_lg = a; end
      else begin m_locked = 1'b1; m_lock = a; end
    end else if (ordy) begin
      m_ov = 1'b0;
    end
  endtask

  initial begin
    // single-beat rotation from reset, ending with last_grant=1
    tbl[0]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b0};
    tbl[1]  = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b0};
    tbl[2]  = '{4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b0};
    tbl[3]  = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b0};
    tbl[4]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b0};
    tbl[5]  = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b0};
    // requester 2 four-beat packet while requester 1 waits
    tbl[6]  = '{4'b0110, 4'b0010, 1'b1, 4'b0100, 1'b0};
    tbl[7]  = '{4'b0110, 4'b0010, 1'b1, 4'b0100, 1'b1};
    tbl[8]  = '{4'b0110, 4'b0010, 1'b1, 4'b0100, 1'b1};
    tbl[9]  = '{4'b0110, 4'b0110, 1'b1, 4'b0100, 1'b1};
    tbl[10] = '{4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b0};
    tbl[11] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0};
    // locked requester 3 with a 2-cycle gap while requester 0 waits
    tbl[12] = '{4'b1001, 4'b0001, 1'b1, 4'b1000, 1'b0};
    tbl[13] = '{4'b0001, 4'b0001, 1'b1, 4'b0000, 1'b1};
    tbl[14] = '{4'b0001, 4'b0001, 1'b1, 4'b0000, 1'b1};
    tbl[15] = '{4'b1001, 4'b1001, 1'b1, 4'b1000, 1'b1};
    tbl[16] = '{4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b0};

    rst_n = 1'b0; in_valid = 4'b0; in_last = 4'b0; in_data = '0; out_ready = 1'b0;
    for (int k = 0; k < 4; k++) req_data[k] = 64'hA0 + 64'(k);
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", out_data, 64'(0));
    chk("rst_out_last", 64'(out_last), 64'(0));
    chk("rst_out_src", 64'(out_src), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      if (i == 6) begin req_data[2] = 64'h20; req_data[1] = 64'h10; end
      if (i == 12) begin req_data[3] = 64'h30; req_data[0] = 64'h00; end
      step(tbl[i].v, tbl[i].l, tbl[i].ordy);
      chk("tbl_ready", 64'(in_ready), 64'(tbl[i].exp_rdy));
      chk("tbl_busy", 64'(busy), 64'(tbl[i].exp_busy));
    end

    // backpressure: one beat pending, out_ready low for 5 cycles
    req_data[2] = 64'h55;
    step(4'b0100, 4'b0100, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(4'b0110, 4'b0110, 1'b0);
      chk("bp_ready", 64'(in_ready), 64'(0));
      chk("bp_valid", 64'(out_valid), 64'(1));
      if (sb.size() > 0) begin
        chk("bp_data", out_data, sb[0].data);
        chk("bp_src", 64'(out_src), 64'(sb[0].src));
      end
    end
    step(4'b0000, 4'b0000, 1'b1);
    step(4'b0000, 4'b0000, 1'b1);
    chk("bp_sb_empty", 64'(sb.size()), 64'(0));

    // reset pulse in the middle of a 3-beat packet from requester 1
    req_data[1] = 64'h71;
    step(4'b0010, 4'b0000, 1'b1);
    step(4'b0010, 4'b0000, 1'b1);
    @(negedge clk);
    #2;
    in_valid = 4'b0;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", 64'(out_valid), 64'(0));
    chk("async_busy", 64'(busy), 64'(0));
    chk("async_out_data", out_data, 64'(0));
    chk("async_in_ready", 64'(in_ready), 64'(0));
    model_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    step(4'b0011, 4'b0011, 1'b1);
    chk("post_rst_prio", 64'(in_ready), 64'(4'b0001));
    step(4'b0000, 4'b0000, 1'b1);
    step(4'b0000, 4'b0000, 1'b1);

    // random stress
    for (int n = 0; n < 10000; n++) begin
      logic [3:0] rv;
      logic [3:0] rl;
      rv = 4'($urandom_range(0, 15));
      for (int k = 0; k < 4; k++) rl[k] = ($urandom_range(0, 2) == 0);
      step(rv, rl, ($urandom_range(0, 3) != 0));
    end
    // finish any open packet, then drain
    for (int n = 0; n < 8; n++) step(4'b1111, 4'b1111, 1'b1);
    for (int n = 0; n < 3; n++) step(4'b0000, 4'b0000, 1'b1);
    chk("final_sb_empty", 64'(sb.size()), 64'(0));
    chk("final_busy", 64'(busy), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
